// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master: FSM state encoding
// and the four CPOL/CPHA mode codes ({CPOL, CPHA}).
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } spi_state_e;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   // Packs polarity and phase into a mode code; bit 1 is CPOL, bit 0 is CPHA.
   function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
      return {cpol, cpha};
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider. Produces a one-clk strobe every DIV clks while
// enabled; 'clear' restarts the count so each transfer begins phase-aligned.
module spi_clk_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic ce_tact
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          ce_q, ce_d;

   // Next count and strobe: wrap at DIV-1 and fire the strobe on the wrap.
   always_comb begin
      cnt_d = cnt_q;
      ce_d  = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
            ce_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Counter and registered strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         ce_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ce_q  <= ce_d;
      end
   end

   assign ce_tact = ce_q;

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, SCLK divider, all four
// CPOL/CPHA modes and N_CS one-hot active-low selects.
// Optional feature: define SPI_LOOPBACK_EN to add the 'loop' input, which
// feeds MOSI back into the receive path in place of MISO.
module spi_master_param
   import spi_pkg::*;
#(
   parameter int W    = 9,
   parameter int DIV  = 4,
   parameter int N_CS = 2,
   parameter int CSW  = (N_CS > 1) ? $clog2(N_CS) : 1
) (
   input  logic            clk,
   input  logic            RESET,
   input  logic            st,
   input  logic [W-1:0]    TX_DAT,
   input  logic            CPOL,
   input  logic            CPHA,
   input  logic [CSW-1:0]  cs_sel,
   input  logic            MISO,
`ifdef SPI_LOOPBACK_EN
   input  logic            loop,
`endif
   output logic            SCLK,
   output logic            MOSI,
   output logic [N_CS-1:0] SS_N,
   output logic [W-1:0]    RX_DAT,
   output logic            LOAD,
   output logic            busy,
   output logic            ce_tact,
   output logic [7:0]      cb_bit
);

   localparam int EW = $clog2(2 * W + 1);

   spi_state_e      state_q, state_d;
   logic [1:0]      mode_q, mode_d;
   logic [CSW-1:0]  cs_q, cs_d;
   logic [W-1:0]    tx_sh_q, tx_sh_d;
   logic [W-1:0]    rx_sh_q, rx_sh_d;
   logic [W-1:0]    rx_dat_q, rx_dat_d;
   logic            load_q, load_d;
   logic            sclk_q, sclk_d;
   logic            mosi_q, mosi_d;
   logic [N_CS-1:0] ss_n_q, ss_n_d;
   logic [7:0]      cb_q, cb_d;
   logic [EW-1:0]   edge_q, edge_d;

   logic            div_clear;
   logic            div_enable;
   logic            ce;
   logic            leading;
   logic            sample_now;
   logic            sample_bit;
   logic            sel_active;

`ifdef SPI_LOOPBACK_EN
   assign sample_bit = loop ? mosi_q : MISO;
`else
   assign sample_bit = MISO;
`endif

   assign div_enable = (state_q != IDLE);

   spi_clk_div #(
      .DIV (DIV)
   ) u_clk_div (
      .clk     (clk),
      .reset   (RESET),
      .clear   (div_clear),
      .enable  (div_enable),
      .ce_tact (ce)
   );

   // Transfer sequencing and shift datapath. A leading edge is the one that
   // moves SCLK away from its idle level; CPHA picks whether that edge samples
   // or shifts. For CPHA=0 the MSB is put on MOSI at start, so the TX register
   // is preloaded already shifted by one.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      cs_d       = cs_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_dat_d   = rx_dat_q;
      load_d     = 1'b0;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cb_d       = cb_q;
      edge_d     = edge_q;
      div_clear  = 1'b0;
      leading    = 1'b0;
      sample_now = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (st) begin
               state_d   = SETUP;
               mode_d    = spi_mode(CPOL, CPHA);
               cs_d      = cs_sel;
               sclk_d    = CPOL;
               rx_sh_d   = '0;
               cb_d      = '0;
               edge_d    = '0;
               div_clear = 1'b1;
               if (!CPHA) begin
                  mosi_d  = TX_DAT[W-1];
                  tx_sh_d = {TX_DAT[W-2:0], 1'b0};
               end else begin
                  mosi_d  = 1'b0;
                  tx_sh_d = TX_DAT;
               end
            end
         end
         SETUP: begin
            if (ce) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (ce) begin
               leading    = (sclk_q == mode_q[1]);
               sample_now = leading ^ mode_q[0];
               sclk_d     = ~sclk_q;
               edge_d     = edge_q + EW'(1);
               if (sample_now) begin
                  rx_sh_d = {rx_sh_q[W-2:0], sample_bit};
                  if (cb_q != 8'(W)) begin
                     cb_d = cb_q + 8'd1;
                  end
               end else begin
                  mosi_d  = tx_sh_q[W-1];
                  tx_sh_d = {tx_sh_q[W-2:0], 1'b0};
               end
               if (edge_q == EW'(2 * W - 1)) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (ce) begin
               state_d  = DONE;
               rx_dat_d = rx_sh_q;
               load_d   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            mosi_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Select decoder: one line low while the next state keeps a slave framed;
   // an out-of-range index selects nobody.
   always_comb begin
      ss_n_d     = '1;
      sel_active = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
      for (int i = 0; i < N_CS; i++) begin
         if (sel_active && (int'(cs_d) == i)) begin
            ss_n_d[i] = 1'b0;
         end
      end
   end

   // State and datapath registers; reset aborts any transfer immediately.
   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q  <= IDLE;
         mode_q   <= '0;
         cs_q     <= '0;
         tx_sh_q  <= '0;
         rx_sh_q  <= '0;
         rx_dat_q <= '0;
         load_q   <= 1'b0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         ss_n_q   <= '1;
         cb_q     <= '0;
         edge_q   <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cs_q     <= cs_d;
         tx_sh_q  <= tx_sh_d;
         rx_sh_q  <= rx_sh_d;
         rx_dat_q <= rx_dat_d;
         load_q   <= load_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         ss_n_q   <= ss_n_d;
         cb_q     <= cb_d;
         edge_q   <= edge_d;
      end
   end

   assign SCLK    = sclk_q;
   assign MOSI    = mosi_q;
   assign SS_N    = ss_n_q;
   assign RX_DAT  = rx_dat_q;
   assign LOAD    = load_q;
   assign busy    = (state_q != IDLE);
   assign ce_tact = ce;
   assign cb_bit  = cb_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param (W=9, DIV=4, N_CS=3 so that the
// select code 3 is representable and out of range). A timing model derives
// every output from the cycle count since the accepted start pulse; the
// slave is played by the bench, presenting each reply bit before it is sampled.
// With SPI_LOOPBACK_EN defined the 'loop' port is connected and exercised.
module tb_spi_master_param;
   import spi_pkg::*;

   localparam int W    = 9;
   localparam int DIV  = 4;
   localparam int N_CS = 3;
   localparam int CSW  = 2;
   localparam int LAT  = (2 * W + 2) * DIV + 1;

   logic            clk;
   logic            RESET;
   logic            st;
   logic [W-1:0]    TX_DAT;
   logic            CPOL;
   logic            CPHA;
   logic [CSW-1:0]  cs_sel;
   logic            MISO;
   logic            loop_r;
   logic            SCLK;
   logic            MOSI;
   logic [N_CS-1:0] SS_N;
   logic [W-1:0]    RX_DAT;
   logic            LOAD;
   logic            busy;
   logic            ce_tact;
   logic [7:0]      cb_bit;

   int checks   = 0;
   int failures = 0;
   bit check_en = 0;

   // Behavioural model state
   bit           m_act = 0;
   int           m_k = 0;
   logic [W-1:0] m_tx = '0;
   logic [W-1:0] m_rxw = '0;
   logic [W-1:0] m_rx_hold = '0;
   bit           m_pol = 0;
   bit           m_pha = 0;
   int           m_cs = 0;
   int           m_cb_hold = 0;
   bit           m_was_busy;
   logic [W-1:0] slave_word = '0;

   int            load_cnt = 0;
   logic [W-1:0]  mosi_cap = '0;

   spi_master_param #(
      .W    (W),
      .DIV  (DIV),
      .N_CS (N_CS)
   ) dut (
      .clk     (clk),
      .RESET   (RESET),
      .st      (st),
      .TX_DAT  (TX_DAT),
      .CPOL    (CPOL),
      .CPHA    (CPHA),
      .cs_sel  (cs_sel),
      .MISO    (MISO),
`ifdef SPI_LOOPBACK_EN
      .loop    (loop_r),
`endif
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .SS_N    (SS_N),
      .RX_DAT  (RX_DAT),
      .LOAD    (LOAD),
      .busy    (busy),
      .ce_tact (ce_tact),
      .cb_bit  (cb_bit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Number of SCLK toggles completed k clks after acceptance: divider strobe j
   // is consumed at clk DIV*j+1, strobe 1 ends SETUP, strobes 2..2W+1 toggle.
   function automatic int toggles(input int k);
      int j;
      if (k < 1) return 0;
      j = (k - 1) / DIV - 1;
      if (j < 0) j = 0;
      if (j > 2 * W) j = 2 * W;
      return j;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model update on each rising edge: reset, age the running transfer, accept st.
   always @(posedge clk) begin
      if (RESET) begin
         m_act     = 0;
         m_pol     = 0;
         m_rx_hold = '0;
         m_cb_hold = 0;
      end else begin
         m_was_busy = m_act;
         if (m_act) begin
            m_k++;
            if (m_k == LAT) m_rx_hold = loop_r ? m_tx : m_rxw;
            if (m_k > LAT) begin
               m_act     = 0;
               m_cb_hold = W;
            end
         end
         if (!m_was_busy && st) begin
            m_act = 1;
            m_k   = 0;
            m_tx  = TX_DAT;
            m_pol = CPOL;
            m_pha = CPHA;
            m_cs  = int'(cs_sel);
            m_rxw = slave_word;
         end
      end
   end

   // Slave: present the next reply bit (index = bits already sampled).
   int s_n, s_cb;
   always @(posedge clk) begin
      #2;
      if (m_act && !loop_r) begin
         s_n  = toggles(m_k);
         s_cb = m_pha ? s_n / 2 : (s_n + 1) / 2;
         if (s_cb < W) MISO = m_rxw[W-1-s_cb];
         else MISO = 1'($urandom);
      end else begin
         MISO = 1'($urandom);
      end
   end

   always @(negedge clk) if (LOAD === 1'b1) load_cnt++;
   always @(posedge SCLK) mosi_cap = {mosi_cap[W-2:0], MOSI};

   // Compare every output against the model on every falling edge.
   int              c_n;
   logic            e_busy, e_load, e_sclk, e_mosi, e_ce;
   int              e_cb;
   logic [N_CS-1:0] e_ss;
   always @(negedge clk) begin
      if (check_en) begin
         if (m_act) begin
            c_n    = toggles(m_k);
            e_busy = 1'b1;
            e_load = (m_k == LAT);
            e_sclk = m_pol ^ c_n[0];
            if (!m_pha) e_mosi = (c_n / 2 < W) ? m_tx[W-1-c_n/2] : 1'b0;
            else e_mosi = (c_n == 0) ? 1'b0 : m_tx[W-1-(c_n-1)/2];
            e_cb = m_pha ? c_n / 2 : (c_n + 1) / 2;
            e_ss = '1;
            if (m_k <= LAT - 1 && m_cs < N_CS) e_ss[m_cs] = 1'b0;
            e_ce = (m_k >= DIV) && (m_k <= LAT - 1) && (m_k % DIV == 0);
         end else begin
            e_busy = 1'b0;
            e_load = 1'b0;
            e_sclk = m_pol;
            e_mosi = 1'b0;
            e_cb   = m_cb_hold;
            e_ss   = '1;
            e_ce   = 1'b0;
         end
         checkOutput("busy", 32'(busy), 32'(e_busy));
         checkOutput("load", 32'(LOAD), 32'(e_load));
         checkOutput("sclk", 32'(SCLK), 32'(e_sclk));
         checkOutput("mosi", 32'(MOSI), 32'(e_mosi));
         checkOutput("ss_n", 32'(SS_N), 32'(e_ss));
         checkOutput("ce_tact", 32'(ce_tact), 32'(e_ce));
         checkOutput("cb_bit", 32'(cb_bit), 32'(e_cb));
         checkOutput("rx_dat", 32'(RX_DAT), 32'(m_rx_hold));
      end
   end

   // Pulse st for one clk with the given settings, then scramble the inputs
   // so that only the latched copies can produce the right result.
   task automatic applyStimulus(input logic [W-1:0] tx, input logic pol, input logic pha,
                                input logic [CSW-1:0] cs, input logic [W-1:0] sw);
      @(posedge clk);
      #1;
      TX_DAT     = tx;
      CPOL       = pol;
      CPHA       = pha;
      cs_sel     = cs;
      slave_word = sw;
      st         = 1'b1;
      @(posedge clk);
      #1;
      st     = 1'b0;
      TX_DAT = W'($urandom);
      CPOL   = 1'($urandom);
      CPHA   = 1'($urandom);
      cs_sel = CSW'($urandom);
   endtask

   // Count clks from acceptance until LOAD is seen; bounded.
   task automatic waitLoad(output int cyc);
      bit got;
      got = 0;
      cyc = 0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         if (LOAD === 1'b1) got = 1;
         else begin
            @(posedge clk);
            cyc++;
         end
      end
      if (!got) checkOutput("load_timeout", 32'd0, 32'd1);
   endtask

   logic [1:0] modes [4] = '{SPI_MODE0, SPI_MODE1, SPI_MODE2, SPI_MODE3};
   int         cyc;
   int         lc0;

   initial begin
      RESET  = 1'b1;
      st     = 1'b0;
      TX_DAT = '0;
      CPOL   = 1'b0;
      CPHA   = 1'b0;
      cs_sel = '0;
      loop_r = 1'b0;
      MISO   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      RESET    = 1'b0;
      check_en = 1;
      @(negedge clk);
      checkOutput("rst_sclk", 32'(SCLK), 32'd0);
      checkOutput("rst_ss_n", 32'(SS_N), 32'h7);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_rx", 32'(RX_DAT), 32'd0);
      repeat (3) @(posedge clk);

      // Same word in all four modes, slave 1 selected.
      foreach (modes[i]) begin
         applyStimulus(9'h17A, modes[i][1], modes[i][0], 2'd1, 9'h1DB);
         checkOutput("ss_cs1", 32'(SS_N), 32'h5);
         waitLoad(cyc);
         checkOutput("latency", 32'(cyc), 32'd81);
         checkOutput("rx_mode", 32'(RX_DAT), 32'h1DB);
         checkOutput("sclk_idle", 32'(SCLK), 32'(modes[i][1]));
         if (modes[i] == SPI_MODE0) checkOutput("mosi_bits", 32'(mosi_cap), 32'b101111010);
         repeat (3) @(posedge clk);
      end

      // Out-of-range select: nobody framed, transfer still completes.
      applyStimulus(9'h0C3, 1'b0, 1'b1, 2'd3, 9'h12E);
      checkOutput("ss_none", 32'(SS_N), 32'h7);
      waitLoad(cyc);
      checkOutput("latency_unsel", 32'(cyc), 32'd81);
      checkOutput("rx_unsel", 32'(RX_DAT), 32'h12E);
      repeat (3) @(posedge clk);

      // st during SHIFT is ignored.
      lc0 = load_cnt;
      applyStimulus(9'h0F1, 1'b1, 1'b1, 2'd2, 9'h055);
      repeat (30) @(posedge clk);
      #1;
      st = 1'b1;
      @(posedge clk);
      #1;
      st = 1'b0;
      repeat (120) @(posedge clk);
      checkOutput("single_load", 32'(load_cnt - lc0), 32'd1);

      // Back-to-back: st in the clk right after LOAD starts a new transfer.
      applyStimulus(9'h1AA, 1'b0, 1'b0, 2'd0, 9'h0F0);
      waitLoad(cyc);
      applyStimulus(9'h033, 1'b1, 1'b0, 2'd0, 9'h10F);
      checkOutput("b2b_busy", 32'(busy), 32'd1);
      waitLoad(cyc);
      checkOutput("b2b_latency", 32'(cyc), 32'd81);
      checkOutput("b2b_rx", 32'(RX_DAT), 32'h10F);
      repeat (3) @(posedge clk);

      // Reset while bit 4 is in flight aborts without LOAD.
      lc0 = load_cnt;
      applyStimulus(9'h155, 1'b1, 1'b0, 2'd0, 9'h0AA);
      repeat (40) @(posedge clk);
      #1;
      RESET = 1'b1;
      @(posedge clk);
      #1;
      RESET = 1'b0;
      checkOutput("abort_ss_n", 32'(SS_N), 32'h7);
      checkOutput("abort_sclk", 32'(SCLK), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_cb", 32'(cb_bit), 32'd0);
      repeat (100) @(posedge clk);
      checkOutput("abort_no_load", 32'(load_cnt - lc0), 32'd0);

`ifdef SPI_LOOPBACK_EN
      loop_r = 1'b1;
      applyStimulus(9'h0A5, 1'b0, 1'b0, 2'd0, 9'h1FF);
      waitLoad(cyc);
      checkOutput("loop_rx0", 32'(RX_DAT), 32'h0A5);
      repeat (3) @(posedge clk);
      applyStimulus(9'h0A5, 1'b1, 1'b1, 2'd1, 9'h000);
      waitLoad(cyc);
      checkOutput("loop_rx3", 32'(RX_DAT), 32'h0A5);
      repeat (3) @(posedge clk);
      loop_r = 1'b0;
`endif

      // Randomised traffic: random settings every clk, sparse st, rare reset.
      repeat (3000) begin
         @(posedge clk);
         #1;
         TX_DAT     = W'($urandom);
         CPOL       = 1'($urandom);
         CPHA       = 1'($urandom);
         cs_sel     = CSW'($urandom_range(0, 3));
         slave_word = W'($urandom);
         st         = ($urandom_range(0, 19) == 0);
         RESET      = ($urandom_range(0, 999) == 0);
      end
      @(posedge clk);
      #1;
      st    = 1'b0;
      RESET = 1'b0;
      repeat (100) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
